// File: rtl/m_load_unit_pkg.sv
// m_load_unit_pkg: load op encodings, address-map bounds and the load legality check
package m_load_unit_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_op_e;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} ld_state_e;

    localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_LO = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI = 32'h0000_7F1B;
    localparam logic [31:0] IG_LO  = 32'h0000_7F20;
    localparam logic [31:0] IG_HI  = 32'h0000_7F23;

    // Timers only accept whole-word accesses; unknown op codes are never legal.
    function automatic logic ld_legal(input logic [2:0] op, input logic [31:0] a);
        logic in_tc;
        logic in_map;
        in_tc  = (a >= TC0_LO && a <= TC0_HI) || (a >= TC1_LO && a <= TC1_HI);
        in_map = a <= DM_HI || in_tc || (a >= IG_LO && a <= IG_HI);
        return in_map && (op == LD_W ? a[1:0] == 2'b00 :
                          (op == LD_H || op == LD_HU) ? !a[0] && !in_tc :
                          (op == LD_B || op == LD_BU) && !in_tc);
    endfunction

endpackage

// File: rtl/m_load_unit_ext.sv
// m_load_ext: selects the addressed byte/halfword/word of a raw word and extends it
module m_load_ext
    import m_load_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  lo,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [15:0] h;
    logic [7:0]  b;

    always_comb begin
        h    = lo[1] ? raw[31:16] : raw[15:0];
        b    = lo[0] ? h[15:8] : h[7:0];
        data = op == LD_H  ? {{16{h[15]}}, h} :
               op == LD_HU ? {16'h0000, h} :
               op == LD_B  ? {{24{b[7]}}, b} :
               op == LD_BU ? {24'h00_0000, b} : raw;
    end

endmodule

// File: rtl/m_load_unit.sv
// m_load_unit: M-stage load engine issuing one bridge read per load and holding the extended result
module m_load_unit
    import m_load_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic        flush,
    input  logic        pipe_adv,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        ld_stall,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic        exc_adel
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

    ld_state_e   state;
    logic [CW-1:0] cnt;
    logic [2:0]  op_q;
    logic [1:0]  lo_q;
    logic [31:0] ext;
    logic        legal;
    logic        cnt_max;

    m_load_ext u_ext (
        .op   (op_q),
        .lo   (lo_q),
        .raw  (bus_rdata),
        .data (ext)
    );

    assign legal    = ld_legal(ld_op, ld_addr);
    assign cnt_max  = cnt == CMAX;
    assign bus_req  = state == S_WAIT;
    assign ld_stall = state == S_WAIT || state == S_DRAIN;
    assign ld_done  = state == S_HOLD;
    assign exc_adel = (state == S_IDLE && ld_valid && !legal) ||
                      (state == S_WAIT && !flush && !bus_ack && cnt_max);

    // cnt defaults to zero so it clears on every state entry and only counts while it stays put
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            lo_q     <= '0;
            bus_addr <= '0;
            ld_data  <= '0;
        end else begin
            cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (ld_valid && legal && !flush) begin
                        state    <= S_WAIT;
                        op_q     <= ld_op;
                        lo_q     <= ld_addr[1:0];
                        bus_addr <= {ld_addr[31:2], 2'b00};
                    end
                end
                S_WAIT: begin
                    if (flush)
                        state <= bus_ack ? S_IDLE : S_DRAIN;
                    else if (bus_ack) begin
                        state   <= S_HOLD;
                        ld_data <= ext;
                    end else if (cnt_max)
                        state <= S_IDLE;
                    else
                        cnt <= cnt + CW'(1);
                end
                S_HOLD: begin
                    if (flush || pipe_adv)
                        state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (bus_ack || cnt_max)
                        state <= S_IDLE;
                    else
                        cnt <= cnt + CW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
